shift_reg_mem_ctrl: RTL and testbench

Sequencer for the 32-entry signed 8-bit shift-register memory. It accepts a stream command and fires the memory's parallel load (`write_enable`). It then shifts the memory one position per accepted output beat, presenting the oldest entry to a downstream consumer under valid/ready back-pressure. The block sits between the command source and the memory's next-state logic. It owns only the update strobes and sequencing state, not the data.

---
 rtl/shift_reg_mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_shift_reg_mem_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_mem_ctrl.sv
// shift_reg_mem_ctrl
// ------------------
// Sequencer for a DEPTH-entry signed 8-bit shift-register memory. A stream
// command fires the memory's parallel load. Each accepted output beat then
// shifts the memory down one slot, so the oldest entry, shift_reg[DEPTH-1],
// is always the beat being offered downstream. This block owns only the
// update strobes and the sequencing state. The data path lives in the
// memory's next-state logic.
//
// Ports
//   clk          : single clock, rising-edge
//   reset        : synchronous, active-high
//   cmd_valid    : stream command offered
//   cmd_len      : beats to stream (saturates at DEPTH)
//   cmd_ready    : command accepted when cmd_valid && cmd_ready
//   abort        : synchronous cancel of the current stream
//   write_enable : memory parallel-load select (load vs. shift)
//   reg_update   : memory register clock-enable
//   out_valid    : shift_reg[DEPTH-1] holds a valid beat
//   out_ready    : consumer accepts the beat
//   out_idx      : index of the current beat within the command
//   busy         : not in IDLE
//   done         : one-cycle pulse after the last beat of a command
//   aborted      : one-cycle pulse after an abort
module shift_reg_mem_ctrl #(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             abort,
  output logic             write_enable,
  output logic             reg_update,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_idx,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_next;
  logic [CNT_W-1:0] beat_q;
  logic [CNT_W-1:0] beat_next;
  logic             aborted_q;
  logic             aborted_next;
  logic [CNT_W-1:0] eff_len;
  logic             last_beat;

  // Longer requests than the memory holds can only ever stream DEPTH beats.
  assign eff_len   = (cmd_len > DEPTH_C) ? DEPTH_C : cmd_len;
  assign last_beat = (beat_q == len_q - ONE_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_next;
      len_q     <= len_next;
      beat_q    <= beat_next;
      aborted_q <= aborted_next;
    end
  end

  always_comb begin
    state_next   = state;
    len_next     = len_q;
    beat_next    = beat_q;
    aborted_next = 1'b0;
    cmd_ready    = 1'b0;
    write_enable = 1'b0;
    reg_update   = 1'b0;
    out_valid    = 1'b0;
    out_idx      = '0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        // An abort in IDLE only blocks acceptance for that one cycle.
        cmd_ready = !abort;
        if (cmd_valid && !abort) begin
          if (eff_len != '0) begin
            // Load strobes are combinational so the memory captures
            // write_data at the same edge that accepts the command.
            write_enable = 1'b1;
            reg_update   = 1'b1;
            len_next     = eff_len;
            beat_next    = '0;
            state_next   = STREAM;
          end else begin
            // Empty command: nothing to load, just report completion.
            state_next = DONE;
          end
        end
      end

      STREAM: begin
        // Forcing out_valid low under abort guarantees no beat is consumed
        // (and the memory does not shift) in the cancel cycle.
        out_valid = !abort;
        out_idx   = beat_q;
        if (abort) begin
          state_next   = IDLE;
          aborted_next = 1'b1;
        end else if (out_ready) begin
          // Shift: write_enable stays low so entry 0 refills with zero.
          reg_update = 1'b1;
          beat_next  = beat_q + ONE_C;
          if (last_beat) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        // Abort is ignored here; completion is already committed.
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // All outputs are quiet while reset is held, whatever the state is.
    if (reset) begin
      cmd_ready    = 1'b0;
      write_enable = 1'b0;
      reg_update   = 1'b0;
      out_valid    = 1'b0;
      out_idx      = '0;
      done         = 1'b0;
    end
  end

  assign busy    = !reset && (state != IDLE);
  assign aborted = !reset && aborted_q;

endmodule

// File: tb/tb_shift_reg_mem_ctrl.sv
// tb_shift_reg_mem_ctrl
// ---------------------
// Directed bench for shift_reg_mem_ctrl. A behavioural copy of the attached
// 32-entry shift-register memory is driven by the DUT strobes. When a
// command is issued, the beats it should produce (write_data[DEPTH-1-k],
// index k) are queued. A negedge monitor pops one entry per fire and
// compares it against the memory head and out_idx.
module tb_shift_reg_mem_ctrl;

  localparam int DEPTH = 32;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic [CNT_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             abort;
  logic             write_enable;
  logic             reg_update;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_idx;
  logic             busy;
  logic             done;
  logic             aborted;

  logic signed [7:0] wd  [DEPTH];
  logic signed [7:0] mem [DEPTH];

  typedef struct {
    logic signed [7:0] data;
    logic [CNT_W-1:0]  idx;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  bit    bp_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  shift_reg_mem_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_len      (cmd_len),
    .cmd_ready    (cmd_ready),
    .abort        (abort),
    .write_enable (write_enable),
    .reg_update   (reg_update),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  // The memory the controller sequences: load on write_enable, otherwise
  // shift toward DEPTH-1 with zero entering at slot 0.
  always @(posedge clk) begin
    if (reg_update) begin
      if (write_enable) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= wd[i];
      end else begin
        for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        mem[0] <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Advance one cycle and scramble the accept-cycle-only inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) wd[i] = 8'($urandom);
    cmd_len = CNT_W'($urandom);
  endtask

  task automatic push_beats(input int eff);
    beat_t b;
    for (int k = 0; k < eff; k++) begin
      b.data = wd[DEPTH-1-k];
      b.idx  = CNT_W'(k);
      sb.push_back(b);
    end
  endtask

  // Present a command for one cycle and check it is accepted with a load.
  task automatic issue(input int len, input bit ramp);
    int eff;
    eff = (len > DEPTH) ? DEPTH : len;
    cyc();
    abort     = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = CNT_W'(len);
    if (ramp) begin
      for (int i = 0; i < DEPTH; i++) wd[i] = 8'(i);
    end
    push_beats(eff);
    @(negedge clk);
    $display("cmd len=%0d eff=%0d ready=%0b we=%0b", len, eff, cmd_ready, write_enable);
    chk1("accept_ready", cmd_ready, 1'b1);
    chk1("accept_we", write_enable, eff != 0);
    chk1("accept_busy", busy, 1'b0);
  endtask

  // Count cycles after the accept cycle until done; check the pulse and the
  // return to IDLE on the following cycle.
  task automatic wait_done(input int exp_n, input string tag);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      cyc();
      cmd_valid = 1'b0;
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_cycle"}, seen ? n : -1, exp_n);
    chk1({tag, "_done_ready"}, cmd_ready, 1'b0);
    chk1({tag, "_done_busy"}, busy, 1'b1);
    chk1({tag, "_done_valid"}, out_valid, 1'b0);
    cyc();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk1({tag, "_done_pulse"}, done, 1'b0);
    chk1({tag, "_idle_ready"}, cmd_ready, 1'b1);
    chk1({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_beats_left"}, sb.size(), 0);
  endtask

  logic  mon_fire;
  beat_t mon_b;

  always @(negedge clk) begin
    mon_fire = out_valid && out_ready;
    chk1("reg_update_rule", reg_update, write_enable || mon_fire);
    chk1("we_only_on_accept", write_enable && !(cmd_valid && cmd_ready), 1'b0);
    if (mon_fire) begin
      chk1("beat_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        mon_b = sb.pop_front();
        $display("beat idx=%0d data=%0d exp_idx=%0d exp_data=%0d",
                 out_idx, mem[DEPTH-1], mon_b.idx, mon_b.data);
        chk("beat_data", 32'(mem[DEPTH-1]), 32'(mon_b.data));
        chk("beat_idx", 32'(out_idx), 32'(mon_b.idx));
      end
    end
  end

  initial begin
    int nfire;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    abort     = 1'b0;
    out_ready = 1'b0;

    // Reset held: everything quiet.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_we", write_enable, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_aborted", aborted, 1'b0);
    chk("rst_idx", 32'(out_idx), 0);

    cyc();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk1("post_rst_ready", cmd_ready, 1'b1);
    chk1("post_rst_busy", busy, 1'b0);
    chk1("post_rst_valid", out_valid, 1'b0);
    chk1("post_rst_done", done, 1'b0);
    chk1("post_rst_aborted", aborted, 1'b0);

    // Full 32-beat stream of a ramp: data 31..0, done at T+33.
    out_ready = 1'b1;
    issue(32, 1'b1);
    wait_done(33, "full");

    // Back-pressure with ready pattern 1,0,0,1,1,0,1.
    issue(4, 1'b0);
    nfire = 0;
    for (int p = 0; p < 7; p++) begin
      cyc();
      cmd_valid = 1'b0;
      out_ready = bp_pat[p];
      @(negedge clk);
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_idx", 32'(out_idx), nfire);
      chk1("bp_reg_update", reg_update, out_ready);
      if (!out_ready && sb.size() != 0) begin
        chk("bp_stall_data", 32'(mem[DEPTH-1]), 32'(sb[0].data));
      end
      if (out_ready) nfire++;
    end
    out_ready = 1'b1;
    wait_done(1, "bp");

    // Saturation, zero length and single beat.
    issue(40, 1'b0);
    wait_done(33, "sat");
    issue(0, 1'b0);
    chk1("zero_reg_update", reg_update, 1'b0);
    wait_done(1, "zero");
    issue(1, 1'b0);
    wait_done(2, "one");

    // Abort on beat 3 of 8.
    issue(8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      cmd_valid = 1'b0;
      @(negedge clk);
    end
    cyc();
    cmd_valid = 1'b0;
    abort     = 1'b1;
    @(negedge clk);
    chk1("ab_valid", out_valid, 1'b0);
    chk1("ab_reg_update", reg_update, 1'b0);
    chk("ab_idx", 32'(out_idx), 3);
    chk1("ab_busy", busy, 1'b1);
    chk1("ab_done", done, 1'b0);
    chk("ab_beats_left", sb.size(), 5);
    cyc();
    abort = 1'b0;
    @(negedge clk);
    $display("abort aborted=%0b done=%0b ready=%0b", aborted, done, cmd_ready);
    chk1("ab_pulse", aborted, 1'b1);
    chk1("ab_no_done", done, 1'b0);
    chk1("ab_idle_busy", busy, 1'b0);
    chk1("ab_ready", cmd_ready, 1'b1);
    if (sb.size() != 0) begin
      chk("ab_mem_held", 32'(mem[DEPTH-1]), 32'(sb[0].data));
    end
    sb.delete();
    cyc();
    @(negedge clk);
    chk1("ab_pulse_end", aborted, 1'b0);
    chk1("ab_no_done2", done, 1'b0);

    // Abort and command together in IDLE: blocked, then accepted.
    cyc();
    cmd_valid = 1'b1;
    cmd_len   = CNT_W'(3);
    abort     = 1'b1;
    @(negedge clk);
    chk1("abidle_ready", cmd_ready, 1'b0);
    chk1("abidle_we", write_enable, 1'b0);
    chk1("abidle_reg_update", reg_update, 1'b0);
    cyc();
    abort     = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = CNT_W'(3);
    push_beats(3);
    @(negedge clk);
    $display("cmd len=3 after blocked cycle ready=%0b we=%0b", cmd_ready, write_enable);
    chk1("abidle_accept", cmd_ready, 1'b1);
    chk1("abidle_accept_we", write_enable, 1'b1);
    chk1("abidle_accept_busy", busy, 1'b0);
    wait_done(4, "abidle");

    // Reset pulsed at beat 5 of 16.
    issue(16, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      cmd_valid = 1'b0;
      @(negedge clk);
    end
    cyc();
    reset     = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_ready", cmd_ready, 1'b0);
    chk1("mid_rst_we", write_enable, 1'b0);
    chk1("mid_rst_reg_update", reg_update, 1'b0);
    chk("mid_rst_idx", 32'(out_idx), 0);
    chk("mid_rst_beats_left", sb.size(), 11);
    cyc();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    $display("reset mid-stream busy=%0b ready=%0b", busy, cmd_ready);
    chk1("mid_rst_idle_ready", cmd_ready, 1'b1);
    chk1("mid_rst_idle_busy", busy, 1'b0);
    chk1("mid_rst_no_done", done, 1'b0);
    chk1("mid_rst_no_aborted", aborted, 1'b0);
    sb.delete();
    issue(5, 1'b0);
    wait_done(6, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
